icache_fill_unit: RTL and testbench

- Direct-mapped instruction cache that answers the fetch stage's per-cycle block-address lookups with a 64-bit instruction block and a valid flag.
- On a miss it issues a tagged load on the shared memory bus. It latches the transaction tag the bus returns, waits for the matching data tag, and fills the line.
- Sits between the fetch stage (upstream) and the memory bus (downstream). It is the responder end of the fetch address/data interface.

---
 rtl/icache_fill_unit_if.sv | 36 +++
 rtl/icache_fill_unit.sv | 120 ++++++++++++
 tb/tb_icache_fill_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/icache_fill_unit_if.sv
// Fetch-side lookup and memory-bus load signals of the instruction cache.
// The cache is the slave end; the fetch stage / memory bus environment is the master end.
interface icache_fill_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] proc2Icache_addr;
    logic [63:0]     Icache_data_out;
    logic            Icache_valid_out;
    logic [1:0]      proc2Imem_command;
    logic [XLEN-1:0] proc2Imem_addr;
    logic [3:0]      Imem2proc_response;
    logic [63:0]     Imem2proc_data;
    logic [3:0]      Imem2proc_tag;

    modport master (
        output proc2Icache_addr,
        input  Icache_data_out,
        input  Icache_valid_out,
        input  proc2Imem_command,
        input  proc2Imem_addr,
        output Imem2proc_response,
        output Imem2proc_data,
        output Imem2proc_tag
    );

    modport slave (
        input  proc2Icache_addr,
        output Icache_data_out,
        output Icache_valid_out,
        output proc2Imem_command,
        output proc2Imem_addr,
        input  Imem2proc_response,
        input  Imem2proc_data,
        input  Imem2proc_tag
    );
endinterface

// File: rtl/icache_fill_unit.sv
// Direct-mapped instruction cache with a single outstanding tagged miss.
// Hits are combinational; a fill becomes visible the cycle after its data tag matches.
module icache_fill_unit #(
    parameter int CACHE_LINES = 32,
    parameter int XLEN        = 32
) (
    input logic              clock,
    input logic              reset,
    icache_fill_unit_if.slave bus
);
    localparam int IDX_BITS = $clog2(CACHE_LINES);
    localparam int TAG_BITS = XLEN - 3 - IDX_BITS;

    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [3:0]            pending_tag_r;
    logic [IDX_BITS-1:0]   miss_idx_r;
    logic [TAG_BITS-1:0]   miss_tag_r;

    logic [CACHE_LINES-1:0] valid_r;
    logic [TAG_BITS-1:0]    tag_r  [CACHE_LINES];
    logic [63:0]            data_r [CACHE_LINES];

    logic [IDX_BITS-1:0]   idx_s;
    logic [TAG_BITS-1:0]   tag_s;
    logic                  hit_s;
    logic                  accept_s;
    logic                  fill_s;

    // Address split and hit detection against the indexed line.
    always_comb begin
        idx_s = bus.proc2Icache_addr[IDX_BITS+2:3];
        tag_s = bus.proc2Icache_addr[XLEN-1:IDX_BITS+3];
        hit_s = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    end

    // Lookup result: zero data whenever there is no hit, and nothing during reset.
    always_comb begin
        if (hit_s && !reset) begin
            bus.Icache_valid_out = 1'b1;
            bus.Icache_data_out  = data_r[idx_s];
        end else begin
            bus.Icache_valid_out = 1'b0;
            bus.Icache_data_out  = 64'd0;
        end
    end

    // Next-state logic and bus request generation.
    always_comb begin
        state_s               = state_r;
        bus.proc2Imem_command = BUS_NONE;
        bus.proc2Imem_addr    = {bus.proc2Icache_addr[XLEN-1:3], 3'b000};
        accept_s              = 1'b0;
        fill_s                = 1'b0;
        case (state_r)
            IDLE: begin
                if (!hit_s && !reset) begin
                    bus.proc2Imem_command = BUS_LOAD;
                    if (bus.Imem2proc_response != 4'd0) begin
                        accept_s = 1'b1;
                        state_s  = WAIT;
                    end else begin
                        state_s  = IDLE;
                    end
                end else begin
                    bus.proc2Imem_command = BUS_NONE;
                end
            end
            WAIT: begin
                // Tag 0 means "no data"; pending_tag is never 0 while waiting.
                if ((bus.Imem2proc_tag != 4'd0) && (bus.Imem2proc_tag == pending_tag_r)) begin
                    fill_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control state: FSM, outstanding transaction and line valid/tag bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= IDLE;
            pending_tag_r <= 4'd0;
            miss_idx_r    <= '0;
            miss_tag_r    <= '0;
            valid_r       <= '0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                pending_tag_r <= bus.Imem2proc_response;
                miss_idx_r    <= idx_s;
                miss_tag_r    <= tag_s;
            end else if (fill_s) begin
                pending_tag_r         <= 4'd0;
                valid_r[miss_idx_r]   <= 1'b1;
                tag_r[miss_idx_r]     <= miss_tag_r;
            end
        end
    end

    // Data array write on fill; contents are only meaningful behind a valid bit.
    always_ff @(posedge clock) begin
        if (fill_s && !reset) begin
            data_r[miss_idx_r] <= bus.Imem2proc_data;
        end
    end
endmodule

// File: tb/tb_icache_fill_unit.sv
// Directed test-plan scenarios plus a randomized phase, all checked against a
// line-level cache model with one outstanding miss.
module tb_icache_fill_unit;
    logic clock;
    logic reset;

    icache_fill_unit_if #(.XLEN(32)) bus ();

    icache_fill_unit #(.CACHE_LINES(32), .XLEN(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: 32 lines, one outstanding transaction.
    bit          m_v [32];
    logic [23:0] m_t [32];
    logic [63:0] m_d [32];
    bit          m_wait;
    logic [3:0]  m_pend;
    int          m_idx;
    logic [23:0] m_tl;

    logic        obs_valid;
    logic [63:0] obs_data;
    logic [1:0]  obs_cmd;
    logic [31:0] obs_addr;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance the model at posedge.
    task automatic cyc(input logic [31:0] a, input logic [3:0] r, input logic [3:0] t,
                       input logic [63:0] d, input bit rs);
        int          idx;
        logic [23:0] tg;
        bit          hit;
        logic [1:0]  e_cmd;
        reset                  = rs;
        bus.proc2Icache_addr   = a;
        bus.Imem2proc_response = r;
        bus.Imem2proc_tag      = t;
        bus.Imem2proc_data     = d;
        idx   = int'(a[7:3]);
        tg    = a[31:8];
        hit   = !rs && m_v[idx] && (m_t[idx] == tg);
        e_cmd = (!rs && !m_wait && !hit) ? 2'd1 : 2'd0;
        @(negedge clock);
        obs_valid = bus.Icache_valid_out;
        obs_data  = bus.Icache_data_out;
        obs_cmd   = bus.proc2Imem_command;
        obs_addr  = bus.proc2Imem_addr;
        chk("model_valid", {63'd0, obs_valid}, {63'd0, hit});
        chk("model_data", obs_data, hit ? m_d[idx] : 64'd0);
        chk("model_cmd", {62'd0, obs_cmd}, {62'd0, e_cmd});
        if (e_cmd == 2'd1) chk("model_addr", {32'd0, obs_addr}, {32'd0, a[31:3], 3'b000});
        @(posedge clock);
        if (rs) begin
            for (int i = 0; i < 32; i++) m_v[i] = 1'b0;
            m_wait = 1'b0;
            m_pend = 4'd0;
        end else if (!m_wait) begin
            if (!hit && r != 4'd0) begin
                m_wait = 1'b1;
                m_pend = r;
                m_idx  = idx;
                m_tl   = tg;
            end
        end else if (t != 4'd0 && t == m_pend) begin
            m_v[m_idx] = 1'b1;
            m_t[m_idx] = m_tl;
            m_d[m_idx] = d;
            m_wait     = 1'b0;
            m_pend     = 4'd0;
        end
        #1;
    endtask

    task automatic do_reset();
        cyc(32'h0, 4'd0, 4'd0, 64'd0, 1'b1);
    endtask

    task automatic fill(input logic [31:0] a, input logic [3:0] tg, input logic [63:0] d);
        cyc(a, tg, 4'd0, 64'd0, 1'b0);
        cyc(a, 4'd0, tg, d, 1'b0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [3:0]  rr;
        logic [3:0]  rt;
        bit          rrs;

        // 1: basic miss and fill with memory latency of 4
        do_reset();
        chk("reset_valid", {63'd0, obs_valid}, 64'd0);
        chk("reset_cmd", {62'd0, obs_cmd}, 64'd0);
        cyc(32'h100, 4'd3, 4'd0, 64'd0, 1'b0);
        chk("t1_cmd", {62'd0, obs_cmd}, 64'd1);
        chk("t1_addr", {32'd0, obs_addr}, 64'h100);
        for (int i = 0; i < 3; i++) cyc(32'h100, 4'd0, 4'd0, 64'd0, 1'b0);
        cyc(32'h100, 4'd0, 4'd3, 64'hDEADBEEF_CAFEF00D, 1'b0);
        chk("t1_no_bypass", {63'd0, obs_valid}, 64'd0);
        cyc(32'h100, 4'd0, 4'd0, 64'd0, 1'b0);
        chk("t1_valid", {63'd0, obs_valid}, 64'd1);
        chk("t1_data", obs_data, 64'hDEADBEEF_CAFEF00D);
        chk("t1_cmd_none", {62'd0, obs_cmd}, 64'd0);

        // 2: rejected requests are reissued; only the matching tag fills
        do_reset();
        cyc(32'h104, 4'd0, 4'd0, 64'd0, 1'b0);
        cyc(32'h104, 4'd0, 4'd0, 64'd0, 1'b0);
        cyc(32'h104, 4'd5, 4'd0, 64'd0, 1'b0);
        chk("t2_cmd", {62'd0, obs_cmd}, 64'd1);
        chk("t2_addr", {32'd0, obs_addr}, 64'h100);
        cyc(32'h104, 4'd0, 4'd2, 64'h1111, 1'b0);
        cyc(32'h104, 4'd0, 4'd3, 64'h2222, 1'b0);
        cyc(32'h104, 4'd0, 4'd0, 64'd0, 1'b0);
        chk("t2_wrong_tags", {63'd0, obs_valid}, 64'd0);
        cyc(32'h104, 4'd0, 4'd5, 64'h0123_4567_89AB_CDEF, 1'b0);
        cyc(32'h104, 4'd0, 4'd0, 64'd0, 1'b0);
        chk("t2_data", obs_data, 64'h0123_4567_89AB_CDEF);

        // 3: conflict eviction at index 0
        do_reset();
        fill(32'h100, 4'd1, 64'hAAAA_0100);
        fill(32'h200, 4'd4, 64'hBBBB_0200);
        cyc(32'h200, 4'd0, 4'd0, 64'd0, 1'b0);
        chk("t3_hit", obs_data, 64'hBBBB_0200);
        cyc(32'h100, 4'd0, 4'd0, 64'd0, 1'b0);
        chk("t3_evicted", {63'd0, obs_valid}, 64'd0);
        chk("t3_reissue", {32'd0, obs_addr}, 64'h100);

        // 4: address change during WAIT
        do_reset();
        cyc(32'h100, 4'd3, 4'd0, 64'd0, 1'b0);
        cyc(32'h108, 4'd0, 4'd0, 64'd0, 1'b0);
        chk("t4_wait_cmd", {62'd0, obs_cmd}, 64'd0);
        cyc(32'h108, 4'd0, 4'd3, 64'hC0DE_0004, 1'b0);
        chk("t4_fill_cmd", {62'd0, obs_cmd}, 64'd0);
        cyc(32'h108, 4'd0, 4'd0, 64'd0, 1'b0);
        chk("t4_next_cmd", {62'd0, obs_cmd}, 64'd1);
        chk("t4_next_addr", {32'd0, obs_addr}, 64'h108);
        cyc(32'h100, 4'd0, 4'd0, 64'd0, 1'b0);
        chk("t4_hit", obs_data, 64'hC0DE_0004);

        // 5: reset abandons an in-flight transaction
        do_reset();
        cyc(32'h100, 4'd7, 4'd0, 64'd0, 1'b0);
        cyc(32'h100, 4'd0, 4'd0, 64'd0, 1'b1);
        chk("t5_rst_cmd", {62'd0, obs_cmd}, 64'd0);
        cyc(32'h100, 4'd0, 4'd7, 64'h5555_5555, 1'b0);
        cyc(32'h100, 4'd0, 4'd0, 64'd0, 1'b0);
        chk("t5_late_tag", {63'd0, obs_valid}, 64'd0);
        chk("t5_reissue", {62'd0, obs_cmd}, 64'd1);

        // 6: hit under miss
        do_reset();
        fill(32'h140, 4'd2, 64'h6666_0140);
        cyc(32'h100, 4'd9, 4'd0, 64'd0, 1'b0);
        cyc(32'h140, 4'd0, 4'd0, 64'd0, 1'b0);
        chk("t6_hum_valid", {63'd0, obs_valid}, 64'd1);
        chk("t6_hum_data", obs_data, 64'h6666_0140);
        chk("t6_hum_cmd", {62'd0, obs_cmd}, 64'd0);

        // Randomized traffic over a small address pool so hits and conflicts are frequent
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            ra  = {22'd0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 3'($urandom)};
            rr  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            rt  = (m_wait && $urandom_range(0, 2) == 0) ? m_pend : 4'($urandom);
            rrs = ($urandom_range(0, 63) == 0);
            cyc(ra, rr, rt, {$urandom, $urandom}, rrs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
